// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : Front-end stall/flush sequencer with fixed-latency divide freeze
//            and a saturating stall-cycle counter.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_is_div,
    input  logic        id_branch_taken,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        mem_wait,
    output logic        pc_stall,
    output logic        fd_stall,
    output logic        fd_flush,
    output logic        de_stall,
    output logic        de_flush,
    output logic        div_start,
    output logic        div_busy,
    output logic [31:0] stall_cycles
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        DIV_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    state_t     state, next_state;
    logic [7:0] cnt, next_cnt;
    logic       load_use;

    // Loads into $0 never create a real dependency.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) && id_valid &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= 8'd0;
            div_busy     <= 1'b0;
            stall_cycles <= 32'd0;
        end else begin
            state    <= next_state;
            cnt      <= next_cnt;
            div_busy <= (next_state == DIV_BUSY);
            if (pc_stall && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        pc_stall   = 1'b0;
        fd_stall   = 1'b0;
        fd_flush   = 1'b0;
        de_stall   = 1'b0;
        de_flush   = 1'b0;
        div_start  = 1'b0;

        if (reset) begin
            next_state = RUN;
            next_cnt   = 8'd0;
        end else if (mem_wait) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
        end else if (state == DIV_BUSY) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
            if (cnt == 8'd0)
                next_state = RUN;
            else
                next_cnt = cnt - 8'd1;
        end else if (load_use) begin
            // Operands are stale this cycle, so branch/divide wait one cycle.
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_flush = 1'b1;
        end else if (id_valid && id_is_div) begin
            div_start  = 1'b1;
            next_state = DIV_BUSY;
            next_cnt   = DIV_LOAD;
        end else if (id_valid && id_branch_taken) begin
            fd_flush = 1'b1;
        end
    end

endmodule
`default_nettype wire
